// File: rtl/excl_monitor.sv
`default_nettype none
//==============================================================================
//  Module      : excl_monitor
//  Description : N-channel mutual-exclusion checker. Flags same-sample
//                overlaps and, optionally, re-acquisition by a conflicting
//                channel during a guard window after the owner releases.
//                Keeps a sticky error flag, a saturating violation counter
//                and a capture of the first violating mask.
//  Revision    : 1.0 - initial release
//==============================================================================
module excl_monitor #(
    parameter int N     = 3,    // monitored channels, sig[0] is the primary
    parameter int MODE  = 0,    // 0: primary-vs-rest, 1: pairwise
    parameter int GUARD = 0,    // guarded cycles after release (0..255)
    parameter int CNT_W = 16    // violation counter width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     sig,
    input  logic             clr,
    output logic             viol,
    output logic             viol_type,
    output logic [N-1:0]     viol_mask,
    output logic             err_sticky,
    output logic [CNT_W-1:0] viol_cnt,
    output logic             first_valid,
    output logic [N-1:0]     first_mask
);

    // Guard counter width; kept at least one bit so GUARD=0 still elaborates.
    localparam int              GW        = $clog2(GUARD + 1);
    localparam int              GCW       = (GW < 1) ? 1 : GW;
    localparam logic [GCW-1:0]  C_GUARD   = GCW'(GUARD);
    localparam logic [GCW-1:0]  C_G_ONE   = GCW'(1);
    localparam logic [GCW-1:0]  C_G_ZERO  = '0;
    localparam logic [N-1:0]    C_ZERO    = '0;
    localparam logic [N-1:0]    C_ONE     = N'(1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    // Two channel sets conflict if they may not be active together.
    // Calling it with a==b gives the same-sample overlap test.
    function automatic logic conflict(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] u;
        logic         res;
        u = a | b;
        if (MODE == 0) begin
            res = (a[0] & (|b[N-1:1])) | (b[0] & (|a[N-1:1]));
        end else begin
            // More than one distinct channel across both sets.
            res = (a != C_ZERO) && (b != C_ZERO) && ((u & (u - C_ONE)) != C_ZERO);
        end
        return res;
    endfunction

    // FSM and ownership tracking
    state_t          state_q, state_d;
    logic [N-1:0]    owner_q, owner_d;
    logic [GCW-1:0]  gcnt_q,  gcnt_d;

    // Registered outputs
    logic            viol_q,       viol_d;
    logic            viol_type_q,  viol_type_d;
    logic [N-1:0]    viol_mask_q,  viol_mask_d;
    logic            sticky_q,     sticky_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic            fvalid_q,     fvalid_d;
    logic [N-1:0]    fmask_q,      fmask_d;

    // Classification intermediates
    logic            overlap_w;
    logic            guard_w;
    logic [CNT_W-1:0] cnt_base_w;
    logic            fvalid_base_w;
    logic [N-1:0]    fmask_base_w;

    // Classify the current sample: overlap wins over a guard violation.
    always_comb begin
        overlap_w   = 1'b0;
        guard_w     = 1'b0;
        viol_d      = 1'b0;
        viol_type_d = 1'b0;
        viol_mask_d = C_ZERO;
        if (en) begin
            overlap_w = conflict(sig, sig);
            guard_w   = !overlap_w && (GUARD > 0) && (state_q != ST_IDLE)
                        && conflict(sig, owner_q);
            if (overlap_w) begin
                // Every set bit pairs with some other set bit in both modes.
                viol_d      = 1'b1;
                viol_type_d = 1'b0;
                viol_mask_d = sig;
            end else if (guard_w) begin
                viol_d      = 1'b1;
                viol_type_d = 1'b1;
                viol_mask_d = sig | owner_q;
            end
        end
    end

    // Ownership FSM next state: tracks owner and the post-release window.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        gcnt_d  = gcnt_q;
        if (!en || viol_d) begin
            // Disabled or just flagged: restart from a clean IDLE.
            state_d = ST_IDLE;
            owner_d = C_ZERO;
            gcnt_d  = C_G_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sig != C_ZERO) begin
                        state_d = ST_OWNED;
                        owner_d = sig;
                    end
                end
                ST_OWNED: begin
                    if (sig != C_ZERO) begin
                        owner_d = sig;
                    end else if (GUARD == 0) begin
                        state_d = ST_IDLE;
                        owner_d = C_ZERO;
                    end else begin
                        // Keep owner_q so the window can test against it.
                        state_d = ST_GUARD;
                        gcnt_d  = C_GUARD;
                    end
                end
                ST_GUARD: begin
                    if (sig == C_ZERO) begin
                        if (gcnt_q == C_G_ONE) begin
                            state_d = ST_IDLE;
                            owner_d = C_ZERO;
                            gcnt_d  = C_G_ZERO;
                        end else begin
                            gcnt_d = gcnt_q - C_G_ONE;
                        end
                    end else begin
                        // Non-conflicting reacquire (conflicts were flagged above).
                        state_d = ST_OWNED;
                        owner_d = sig;
                        gcnt_d  = C_G_ZERO;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    owner_d = C_ZERO;
                    gcnt_d  = C_G_ZERO;
                end
            endcase
        end
    end

    // Status next state: clr clears first, a same-cycle violation then applies.
    always_comb begin
        cnt_base_w    = clr ? '0 : cnt_q;
        fvalid_base_w = clr ? 1'b0 : fvalid_q;
        fmask_base_w  = clr ? C_ZERO : fmask_q;

        cnt_d    = cnt_base_w;
        fvalid_d = fvalid_base_w;
        fmask_d  = fmask_base_w;
        sticky_d = clr ? 1'b0 : sticky_q;

        if (viol_d) begin
            sticky_d = 1'b1;
            if (cnt_base_w != C_CNT_MAX) begin
                cnt_d = cnt_base_w + C_CNT_ONE;
            end
            if (!fvalid_base_w) begin
                fvalid_d = 1'b1;
                fmask_d  = viol_mask_d;
            end
        end
    end

    // FSM state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= C_ZERO;
            gcnt_q  <= C_G_ZERO;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            gcnt_q  <= gcnt_d;
        end
    end

    // Output registers; everything visible one cycle after the sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            viol_q      <= 1'b0;
            viol_type_q <= 1'b0;
            viol_mask_q <= C_ZERO;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
            fvalid_q    <= 1'b0;
            fmask_q     <= C_ZERO;
        end else begin
            viol_q      <= viol_d;
            viol_type_q <= viol_type_d;
            viol_mask_q <= viol_mask_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            fvalid_q    <= fvalid_d;
            fmask_q     <= fmask_d;
        end
    end

    assign viol        = viol_q;
    assign viol_type   = viol_type_q;
    assign viol_mask   = viol_mask_q;
    assign err_sticky  = sticky_q;
    assign viol_cnt    = cnt_q;
    assign first_valid = fvalid_q;
    assign first_mask  = fmask_q;

endmodule
`default_nettype wire

// File: tb/tb_excl_monitor.sv
`default_nettype none
//==============================================================================
//  Module      : tb_excl_monitor
//  Description : Self-checking bench for excl_monitor. Five instances with
//                different MODE/GUARD/CNT_W share one stimulus stream; each
//                table row names the instance whose outputs it checks.
//  Revision    : 1.0 - initial release
//==============================================================================
module tb_excl_monitor;

    logic clk;
    logic rst;
    logic en;
    logic clr;
    logic [2:0] sig;

    // Per-instance outputs: 0 MODE0/G0, 1 MODE1/G0, 2 MODE0/G2, 3 MODE0/G1, 4 MODE0/G0/CNT_W=2
    logic        viol_a   [5];
    logic        vtype_a  [5];
    logic [2:0]  mask_a   [5];
    logic        sticky_a [5];
    logic [15:0] cnt_a    [4];
    logic [1:0]  cnt4;
    logic        fv_a     [5];
    logic [2:0]  fm_a     [5];

    excl_monitor #(.N(3), .MODE(0), .GUARD(0), .CNT_W(16)) u_d0 (
        .clk(clk), .rst(rst), .en(en), .sig(sig), .clr(clr),
        .viol(viol_a[0]), .viol_type(vtype_a[0]), .viol_mask(mask_a[0]),
        .err_sticky(sticky_a[0]), .viol_cnt(cnt_a[0]),
        .first_valid(fv_a[0]), .first_mask(fm_a[0]));

    excl_monitor #(.N(3), .MODE(1), .GUARD(0), .CNT_W(16)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .sig(sig), .clr(clr),
        .viol(viol_a[1]), .viol_type(vtype_a[1]), .viol_mask(mask_a[1]),
        .err_sticky(sticky_a[1]), .viol_cnt(cnt_a[1]),
        .first_valid(fv_a[1]), .first_mask(fm_a[1]));

    excl_monitor #(.N(3), .MODE(0), .GUARD(2), .CNT_W(16)) u_d2 (
        .clk(clk), .rst(rst), .en(en), .sig(sig), .clr(clr),
        .viol(viol_a[2]), .viol_type(vtype_a[2]), .viol_mask(mask_a[2]),
        .err_sticky(sticky_a[2]), .viol_cnt(cnt_a[2]),
        .first_valid(fv_a[2]), .first_mask(fm_a[2]));

    excl_monitor #(.N(3), .MODE(0), .GUARD(1), .CNT_W(16)) u_d3 (
        .clk(clk), .rst(rst), .en(en), .sig(sig), .clr(clr),
        .viol(viol_a[3]), .viol_type(vtype_a[3]), .viol_mask(mask_a[3]),
        .err_sticky(sticky_a[3]), .viol_cnt(cnt_a[3]),
        .first_valid(fv_a[3]), .first_mask(fm_a[3]));

    excl_monitor #(.N(3), .MODE(0), .GUARD(0), .CNT_W(2)) u_d4 (
        .clk(clk), .rst(rst), .en(en), .sig(sig), .clr(clr),
        .viol(viol_a[4]), .viol_type(vtype_a[4]), .viol_mask(mask_a[4]),
        .err_sticky(sticky_a[4]), .viol_cnt(cnt4),
        .first_valid(fv_a[4]), .first_mask(fm_a[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          d;      // instance checked
        logic        r;      // rst
        logic        e;      // en
        logic        c;      // clr
        logic [2:0]  s;      // sig
        logic        v;      // expected viol
        logic        t;      // expected viol_type
        logic [2:0]  m;      // expected viol_mask
        logic        st;     // expected err_sticky
        logic [15:0] cnt;    // expected viol_cnt
        logic        fv;     // expected first_valid
        logic [2:0]  fm;     // expected first_mask
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_chk;
    int   n_pass;

    function automatic void add(int d, logic r, logic e, logic c, logic [2:0] s,
                                logic v, logic t, logic [2:0] m, logic st,
                                logic [15:0] cnt, logic fv, logic [2:0] fm);
        vec_t x;
        x.d = d; x.r = r; x.e = e; x.c = c; x.s = s;
        x.v = v; x.t = t; x.m = m; x.st = st; x.cnt = cnt; x.fv = fv; x.fm = fm;
        tbl.push_back(x);
    endfunction

    // Shorthand: reset row (all outputs must read zero afterwards).
    function automatic void add_rst(int d);
        add(d, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 16'd0, 1'b0, 3'b000);
    endfunction

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    initial begin
        vec_t v;
        vec_t e;
        logic [15:0] got_cnt;
        n_chk  = 0;
        n_pass = 0;
        rst = 1'b1;
        en  = 1'b0;
        clr = 1'b0;
        sig = 3'b000;

        // ---- MODE0 GUARD0 sweep: flags 3,5,7; 6 may coexist ----
        add_rst(0);
        add(0,0,1,0,3'd0, 0,0,3'b000, 0,16'd0, 0,3'b000);
        add(0,0,1,0,3'd1, 0,0,3'b000, 0,16'd0, 0,3'b000);
        add(0,0,1,0,3'd2, 0,0,3'b000, 0,16'd0, 0,3'b000);
        add(0,0,1,0,3'd3, 1,0,3'b011, 1,16'd1, 1,3'b011);
        add(0,0,1,0,3'd4, 0,0,3'b000, 1,16'd1, 1,3'b011);
        add(0,0,1,0,3'd5, 1,0,3'b101, 1,16'd2, 1,3'b011);
        add(0,0,1,0,3'd6, 0,0,3'b000, 1,16'd2, 1,3'b011);
        add(0,0,1,0,3'd7, 1,0,3'b111, 1,16'd3, 1,3'b011);
        add(0,0,1,0,3'd0, 0,0,3'b000, 1,16'd3, 1,3'b011);
        // ---- MODE1 sweep: flags 3,5,6,7 ----
        add_rst(1);
        add(1,0,1,0,3'd0, 0,0,3'b000, 0,16'd0, 0,3'b000);
        add(1,0,1,0,3'd1, 0,0,3'b000, 0,16'd0, 0,3'b000);
        add(1,0,1,0,3'd2, 0,0,3'b000, 0,16'd0, 0,3'b000);
        add(1,0,1,0,3'd3, 1,0,3'b011, 1,16'd1, 1,3'b011);
        add(1,0,1,0,3'd4, 0,0,3'b000, 1,16'd1, 1,3'b011);
        add(1,0,1,0,3'd5, 1,0,3'b101, 1,16'd2, 1,3'b011);
        add(1,0,1,0,3'd6, 1,0,3'b110, 1,16'd3, 1,3'b011);
        add(1,0,1,0,3'd7, 1,0,3'b111, 1,16'd4, 1,3'b011);
        add(1,0,1,0,3'd0, 0,0,3'b000, 1,16'd4, 1,3'b011);
        // ---- GUARD=2: 001,001,000,010 -> guard violation ----
        add_rst(2);
        add(2,0,1,0,3'b001, 0,0,3'b000, 0,16'd0, 0,3'b000);
        add(2,0,1,0,3'b001, 0,0,3'b000, 0,16'd0, 0,3'b000);
        add(2,0,1,0,3'b000, 0,0,3'b000, 0,16'd0, 0,3'b000);
        add(2,0,1,0,3'b010, 1,1,3'b011, 1,16'd1, 1,3'b011);
        // ---- GUARD=2: 001,000,000,010 -> last guarded sample ----
        add_rst(2);
        add(2,0,1,0,3'b001, 0,0,3'b000, 0,16'd0, 0,3'b000);
        add(2,0,1,0,3'b000, 0,0,3'b000, 0,16'd0, 0,3'b000);
        add(2,0,1,0,3'b000, 0,0,3'b000, 0,16'd0, 0,3'b000);
        add(2,0,1,0,3'b010, 1,1,3'b011, 1,16'd1, 1,3'b011);
        // ---- GUARD=2: 001,000,000,000,010 -> window expired ----
        add_rst(2);
        add(2,0,1,0,3'b001, 0,0,3'b000, 0,16'd0, 0,3'b000);
        add(2,0,1,0,3'b000, 0,0,3'b000, 0,16'd0, 0,3'b000);
        add(2,0,1,0,3'b000, 0,0,3'b000, 0,16'd0, 0,3'b000);
        add(2,0,1,0,3'b000, 0,0,3'b000, 0,16'd0, 0,3'b000);
        add(2,0,1,0,3'b010, 0,0,3'b000, 0,16'd0, 0,3'b000);
        // ---- Direct handover 001->010: ok with GUARD=0, flagged with GUARD=1 ----
        add_rst(0);
        add(0,0,1,0,3'b001, 0,0,3'b000, 0,16'd0, 0,3'b000);
        add(0,0,1,0,3'b010, 0,0,3'b000, 0,16'd0, 0,3'b000);
        add_rst(3);
        add(3,0,1,0,3'b001, 0,0,3'b000, 0,16'd0, 0,3'b000);
        add(3,0,1,0,3'b010, 1,1,3'b011, 1,16'd1, 1,3'b011);
        // ---- CNT_W=2: persistent overlap saturates at 3; clr interplay ----
        add_rst(4);
        add(4,0,1,0,3'b011, 1,0,3'b011, 1,16'd1, 1,3'b011);
        add(4,0,1,0,3'b011, 1,0,3'b011, 1,16'd2, 1,3'b011);
        add(4,0,1,0,3'b011, 1,0,3'b011, 1,16'd3, 1,3'b011);
        add(4,0,1,0,3'b011, 1,0,3'b011, 1,16'd3, 1,3'b011);
        add(4,0,1,0,3'b011, 1,0,3'b011, 1,16'd3, 1,3'b011);
        add(4,0,1,1,3'b101, 1,0,3'b101, 1,16'd1, 1,3'b101);
        add(4,0,1,1,3'b000, 0,0,3'b000, 0,16'd0, 0,3'b000);
        add(4,0,1,0,3'b000, 0,0,3'b000, 0,16'd0, 0,3'b000);
        // ---- Reset mid-GUARD discards the window ----
        add_rst(2);
        add(2,0,1,0,3'b011, 1,0,3'b011, 1,16'd1, 1,3'b011);
        add(2,0,1,0,3'b001, 0,0,3'b000, 1,16'd1, 1,3'b011);
        add(2,0,1,0,3'b000, 0,0,3'b000, 1,16'd1, 1,3'b011);
        add_rst(2);
        add(2,0,1,0,3'b010, 0,0,3'b000, 0,16'd0, 0,3'b000);
        // ---- en=0: no checking, FSM forced IDLE, status held ----
        add(2,0,1,0,3'b011, 1,0,3'b011, 1,16'd1, 1,3'b011);
        add(2,0,1,0,3'b001, 0,0,3'b000, 1,16'd1, 1,3'b011);
        add(2,0,1,0,3'b000, 0,0,3'b000, 1,16'd1, 1,3'b011);
        add(2,0,0,0,3'b111, 0,0,3'b000, 1,16'd1, 1,3'b011);
        add(2,0,0,0,3'b111, 0,0,3'b000, 1,16'd1, 1,3'b011);
        add(2,0,1,0,3'b010, 0,0,3'b000, 1,16'd1, 1,3'b011);

        // Apply each row, queue its expectation, compare after the next edge.
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(negedge clk);
            rst = v.r;
            en  = v.e;
            clr = v.c;
            sig = v.s;
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL row%0d.queue: got empty scoreboard expected one entry", i);
            end else begin
                e = exp_q.pop_front();
                got_cnt = (e.d == 4) ? {14'd0, cnt4} : cnt_a[e.d];
                check($sformatf("row%0d.d%0d.viol", i, e.d),   {15'd0, viol_a[e.d]},   {15'd0, e.v});
                check($sformatf("row%0d.d%0d.type", i, e.d),   {15'd0, vtype_a[e.d]},  {15'd0, e.t});
                check($sformatf("row%0d.d%0d.mask", i, e.d),   {13'd0, mask_a[e.d]},   {13'd0, e.m});
                check($sformatf("row%0d.d%0d.sticky", i, e.d), {15'd0, sticky_a[e.d]}, {15'd0, e.st});
                check($sformatf("row%0d.d%0d.cnt", i, e.d),    got_cnt,                e.cnt);
                check($sformatf("row%0d.d%0d.fvalid", i, e.d), {15'd0, fv_a[e.d]},     {15'd0, e.fv});
                check($sformatf("row%0d.d%0d.fmask", i, e.d),  {13'd0, fm_a[e.d]},     {13'd0, e.fm});
            end
        end

        check("scoreboard.drained", 16'(exp_q.size()), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
